// File: rtl/mul_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and digit encoding.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Radix-4 Booth digit: magnitude selects {0,1,2}, neg flips the sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

endpackage : mul_pkg

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps the window {a[2i+1], a[2i], a[2i-1]} to a digit.
module booth_r4_encoder
  import mul_pkg::*;
(
  input  logic [2:0]   win_i,
  output booth_digit_t digit_o
);

  // Digit table: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
  always_comb begin
    digit_o = '0;
    unique case (win_i)
      3'b001, 3'b010: digit_o.one = 1'b1;
      3'b011:         digit_o.two = 1'b1;
      3'b100: begin
        digit_o.neg = 1'b1;
        digit_o.two = 1'b1;
      end
      3'b101, 3'b110: begin
        digit_o.neg = 1'b1;
        digit_o.one = 1'b1;
      end
      default: digit_o = '0;
    endcase
  end

endmodule : booth_r4_encoder

// File: rtl/booth_multiplier_param.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, one digit per cycle.
// Handshake: op_start (sampled in IDLE), op_clear (abort, highest priority),
// busy while iterating, op_done held in DONE until op_clear.
module booth_multiplier_param
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned ITER = WIDTH / 2 + 1;
  localparam int unsigned EXTW = WIDTH + 2;
  localparam int unsigned ACCW = 2 * WIDTH + 4;
  localparam int unsigned CNTW = $clog2(ITER + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(ITER - 1);

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [EXTW-1:0]     mplr_q, mplr_d;
  logic                prev_q, prev_d;
  logic [ACCW-1:0]     mcand_q, mcand_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]  result_q, result_d;

  booth_digit_t        digit;
  logic [ACCW-1:0]     pp;
  logic [ACCW-1:0]     acc_sum;
  logic                a_msb, b_msb, zero_op;
  logic [EXTW-1:0]     a_ext;
  logic [ACCW-1:0]     b_ext;

  // Operand extension: two guard bits make both operands exact in either mode,
  // so the top digit consumes the sign (or zero) extension naturally.
  assign a_msb   = signed_mode & multiplier[WIDTH-1];
  assign b_msb   = signed_mode & multiplicand[WIDTH-1];
  assign a_ext   = {{2{a_msb}}, multiplier};
  assign b_ext   = {{(ACCW-WIDTH){b_msb}}, multiplicand};
  assign zero_op = (multiplier == '0) || (multiplicand == '0);

  booth_r4_encoder u_enc (
    .win_i   ({mplr_q[1:0], prev_q}),
    .digit_o (digit)
  );

  // Partial product add: the multiplicand register is pre-shifted by 2i,
  // so the digit only selects 0/B/2B and the sign.
  always_comb begin
    pp = '0;
    if (digit.two) begin
      pp = mcand_q << 1;
    end else if (digit.one) begin
      pp = mcand_q;
    end
    acc_sum = digit.neg ? (acc_q - pp) : (acc_q + pp);
  end

  // Next-state and datapath control: op_clear > op_start > iteration
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mplr_d   = mplr_q;
    prev_d   = prev_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;

    if (op_clear) begin
      state_d  = ST_IDLE;
      result_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            mplr_d   = a_ext;
            prev_d   = 1'b0;
            mcand_d  = b_ext;
            acc_d    = '0;
            result_d = '0;
            cnt_d    = '0;
            state_d  = zero_op ? ST_DONE : ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc_d   = acc_sum;
          mplr_d  = mplr_q >> 2;
          prev_d  = mplr_q[1];
          mcand_d = mcand_q << 2;
          cnt_d   = cnt_q + CNTW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = ST_DONE;
            result_d = acc_sum[2*WIDTH-1:0];
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mplr_q   <= '0;
      prev_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mplr_q   <= mplr_d;
      prev_q   <= prev_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q == ST_EXEC);
  assign op_done = (state_q == ST_DONE);
  assign result  = result_q;

endmodule : booth_multiplier_param

// File: tb/tb_booth_multiplier_param.sv
// Self-checking bench: 64-bit and 8-bit instances against an arithmetic model.
module tb_booth_multiplier_param;

  localparam int unsigned ITER64 = 33;
  localparam int unsigned ITER8  = 5;
  localparam int          LIM    = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         w_start = 1'b0, w_clear = 1'b0, w_sm = 1'b0;
  logic [63:0]  w_a = '0, w_b = '0;
  logic         w_busy, w_done;
  logic [127:0] w_res;

  logic         n_start = 1'b0, n_clear = 1'b0, n_sm = 1'b0;
  logic [7:0]   n_a = '0, n_b = '0;
  logic         n_busy, n_done;
  logic [15:0]  n_res;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  always #5 clk = ~clk;

  booth_multiplier_param #(.WIDTH(64)) u_dut64 (
    .clk          (clk),
    .reset_n      (rst_n),
    .op_start     (w_start),
    .op_clear     (w_clear),
    .signed_mode  (w_sm),
    .multiplier   (w_a),
    .multiplicand (w_b),
    .busy         (w_busy),
    .op_done      (w_done),
    .result       (w_res)
  );

  booth_multiplier_param #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .reset_n      (rst_n),
    .op_start     (n_start),
    .op_clear     (n_clear),
    .signed_mode  (n_sm),
    .multiplier   (n_a),
    .multiplicand (n_b),
    .busy         (n_busy),
    .op_done      (n_done),
    .result       (n_res)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact product of the w-bit operands interpreted per mode, kept to 2w bits
  function automatic logic [127:0] ref_mul(input int unsigned w, input bit sm,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, mw, mp;
    mw = (128'd1 << w) - 128'd1;
    mp = (128'd1 << (2 * w)) - 128'd1;
    ea = {64'd0, a} & mw;
    eb = {64'd0, b} & mw;
    if (sm && ea[w-1]) ea = ea | ~mw;
    if (sm && eb[w-1]) eb = eb | ~mw;
    return (ea * eb) & mp;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'(($urandom_range(0, 15)));
      1: v = 64'h8000_0000_0000_0000;
      2: v = '1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic logic [7:0] rnd8();
    logic [7:0] v;
    case ($urandom_range(0, 7))
      0: v = 8'h00;
      1: v = 8'h80;
      2: v = 8'hFF;
      3: v = 8'h7F;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // One 64-bit operation; optionally pokes op_start mid-EXEC at iteration poke_at
  task automatic run64(input bit sm, input logic [63:0] a, input logic [63:0] b,
                       input int poke_at, output logic [127:0] res_o);
    int n, nb, exp_n;
    logic [127:0] exp;
    exp   = ref_mul(64, sm, a, b);
    exp_n = (a == 0 || b == 0) ? 0 : int'(ITER64);
    @(negedge clk);
    w_sm = sm; w_a = a; w_b = b; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0; w_a = rnd64(); w_b = rnd64(); w_sm = ~sm;
    n = 0; nb = 0;
    while (!w_done && n < LIM) begin
      if (w_busy) nb++;
      if (n == poke_at) begin
        w_start = 1'b1; w_a = rnd64(); w_b = rnd64();
      end
      @(posedge clk); #1;
      w_start = 1'b0;
      n++;
    end
    check("lat64", 128'(n), 128'(exp_n));
    check("busy64", 128'(nb), 128'(exp_n));
    check("res64", w_res, exp);
    res_o = w_res;
    // op_start in DONE is ignored; result holds
    w_start = 1'b1; w_a = rnd64(); w_b = rnd64();
    @(posedge clk); #1;
    w_start = 1'b0;
    check("hold_done64", 128'(w_done), 128'(1));
    check("hold_res64", w_res, exp);
    w_clear = 1'b1;
    @(posedge clk); #1;
    w_clear = 1'b0;
    check("clr_done64", 128'(w_done), 128'(0));
    check("clr_res64", w_res, 128'(0));
  endtask

  task automatic run8(input bit sm, input logic [7:0] a, input logic [7:0] b);
    int n, nb, exp_n;
    logic [127:0] exp;
    exp   = ref_mul(8, sm, {56'd0, a}, {56'd0, b});
    exp_n = (a == 0 || b == 0) ? 0 : int'(ITER8);
    @(negedge clk);
    n_sm = sm; n_a = a; n_b = b; n_start = 1'b1;
    @(posedge clk); #1;
    n_start = 1'b0; n_a = rnd8(); n_b = rnd8();
    n = 0; nb = 0;
    while (!n_done && n < LIM) begin
      if (n_busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    check("lat8", 128'(n), 128'(exp_n));
    check("busy8", 128'(nb), 128'(exp_n));
    check("res8", 128'(n_res), exp);
    n_clear = 1'b1;
    @(posedge clk); #1;
    n_clear = 1'b0;
    check("clr_done8", 128'(n_done), 128'(0));
    check("clr_res8", 128'(n_res), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic [127:0] r;
    logic [7:0]   corners [6];
    int           cnt;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy64", 128'(w_busy), 128'(0));
    check("rst_done64", 128'(w_done), 128'(0));
    check("rst_res64", w_res, 128'(0));
    check("rst_res8", 128'({n_busy, n_done, n_res}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed 64-bit cases with known products
    run64(1'b0, 64'd5, 64'd7, -1, r);
    check("u5x7", r, 128'd35);
    run64(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, -1, r);
    check("s_m3x7", r, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
    run64(1'b0, '1, '1, -1, r);
    check("u_max_sq", r, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run64(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, -1, r);
    check("s_min_sq", r, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run64(1'b1, 64'h8000_0000_0000_0000, 64'd1, -1, r);
    check("s_min_x1", r, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);
    run64(1'b0, 64'd0, 64'h12345, -1, r);
    check("zero_op", r, 128'd0);

    // op_start during EXEC is ignored
    run64(1'b1, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 10, r);

    // op_clear at EXEC iteration 10
    @(negedge clk);
    w_sm = 1'b0; w_a = 64'd123456789; w_b = 64'd987654321; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    w_clear = 1'b1;
    @(posedge clk); #1;
    w_clear = 1'b0;
    check("abort_busy", 128'(w_busy), 128'(0));
    check("abort_res", w_res, 128'(0));
    cnt = 0;
    for (int i = 0; i < int'(ITER64) + 5; i++) begin
      if (w_done || w_busy) cnt++;
      @(posedge clk); #1;
    end
    check("abort_stays_idle", 128'(cnt), 128'(0));

    // op_clear and op_start together in IDLE
    @(negedge clk);
    w_a = 64'd3; w_b = 64'd4; w_start = 1'b1; w_clear = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0; w_clear = 1'b0;
    check("clr_start_busy", 128'(w_busy), 128'(0));
    check("clr_start_done", 128'(w_done), 128'(0));

    // Asynchronous reset mid-EXEC
    @(negedge clk);
    w_sm = 1'b0; w_a = 64'd5; w_b = 64'd7; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", 128'(w_busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(w_busy), 128'(0));
    check("arst_done", 128'(w_done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while holding a nonzero result in DONE
    @(negedge clk);
    w_a = 64'd5; w_b = 64'd7; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    repeat (ITER64) @(posedge clk);
    #1;
    check("pre_rst_res", w_res, 128'd35);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res", w_res, 128'(0));
    check("arst_done_hold", 128'(w_done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized 64-bit operations
    for (int i = 0; i < 120; i++) begin
      run64(1'($urandom), rnd64(), rnd64(), -1, r);
    end

    // 8-bit corner cross product in both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          run8(1'(m), corners[i], corners[j]);
        end
      end
    end

    // Randomized 8-bit operations
    for (int i = 0; i < 3000; i++) begin
      run8(1'($urandom), rnd8(), rnd8());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_booth_multiplier_param
